// File: rtl/icache_pkg.sv
// Shared types and helpers for the direct-mapped instruction cache.
// The optional ICACHE_STATS_EN hit/miss counters live in icache_dm.
package icache_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      REQ  = 2'd1,
      FILL = 2'd2
   } state_t;

   // Instruction returned when the lookup does not hit
   localparam logic [31:0] NOP = 32'h0;

   // Word-offset field width inside a line
   function automatic int calc_off_w(input int line_words);
      return $clog2(line_words);
   endfunction

   // Line-index field width
   function automatic int calc_idx_w(input int num_lines);
      return $clog2(num_lines);
   endfunction

   // Tag width: 30 word-address bits minus offset and index fields
   function automatic int calc_tag_w(input int num_lines, input int line_words);
      return 30 - $clog2(line_words) - $clog2(num_lines);
   endfunction

endpackage

// File: rtl/icache_tagmem.sv
// Valid/tag store for icache_dm: combinational lookup compare, bulk
// invalidate of every line and a single-line tag write at fill completion.
module icache_tagmem
   import icache_pkg::*;
#(
   parameter int NUM_LINES = 16,
   parameter int IDX_W     = calc_idx_w(NUM_LINES),
   parameter int TAG_W     = 24
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [IDX_W-1:0] lookup_idx,
   input  logic [TAG_W-1:0] lookup_tag,
   output logic             lookup_hit,
   input  logic             inv_all,
   input  logic             wr_en,
   input  logic [IDX_W-1:0] wr_idx,
   input  logic [TAG_W-1:0] wr_tag,
   input  logic             wr_valid
);

   logic [NUM_LINES-1:0] valid_q;
   logic [TAG_W-1:0]     tag_q [NUM_LINES];

   assign lookup_hit = valid_q[lookup_idx] & (tag_q[lookup_idx] == lookup_tag);

   // Valid bits: the only reset state; invalidate wins over a line write
   always_ff @(posedge clk) begin
      if (reset) begin
         valid_q <= '0;
      end else if (inv_all) begin
         valid_q <= '0;
      end else if (wr_en) begin
         valid_q[wr_idx] <= wr_valid;
      end
   end

   // Tag storage carries no reset; a tag is meaningless until its valid bit is set
   always_ff @(posedge clk) begin
      if (wr_en) begin
         tag_q[wr_idx] <= wr_tag;
      end
   end

endmodule

// File: rtl/icache_dm.sv
// Direct-mapped instruction cache with combinational hit path and a
// request/grant + read-valid line refill. Define ICACHE_STATS_EN to build
// the hit/miss counters; otherwise hit_cnt_o/miss_cnt_o are tied to zero.
module icache_dm
   import icache_pkg::*;
#(
   parameter int NUM_LINES  = 16,
   parameter int LINE_WORDS = 4
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        fetch_req_i,
   input  logic [31:0] pc_i,
   output logic [31:0] instr_o,
   output logic        stall_o,
   input  logic        inv_i,
   output logic        mem_req_o,
   output logic [31:0] mem_addr_o,
   input  logic        mem_gnt_i,
   input  logic        mem_rvalid_i,
   input  logic [31:0] mem_rdata_i,
   output logic [31:0] hit_cnt_o,
   output logic [31:0] miss_cnt_o
);

   localparam int OFF_W = calc_off_w(LINE_WORDS);
   localparam int IDX_W = calc_idx_w(NUM_LINES);
   localparam int TAG_W = calc_tag_w(NUM_LINES, LINE_WORDS);

   state_t           state;
   logic [OFF_W-1:0] beat;
   logic             inv_pend;

   logic [31:0]      data_q [NUM_LINES][LINE_WORDS];

   logic [OFF_W-1:0] pc_off;
   logic [IDX_W-1:0] pc_idx;
   logic [TAG_W-1:0] pc_tag;
   logic [IDX_W-1:0] miss_idx;
   logic [TAG_W-1:0] miss_tag;
   logic             tag_hit;
   logic             hit;
   logic             miss_start;
   logic             fill_we;
   logic             last_beat;
   logic             unused_pc_bits;

   assign pc_off   = pc_i[OFF_W+1:2];
   assign pc_idx   = pc_i[OFF_W+IDX_W+1:OFF_W+2];
   assign pc_tag   = pc_i[31:OFF_W+IDX_W+2];
   assign miss_idx = mem_addr_o[OFF_W+IDX_W+1:OFF_W+2];
   assign miss_tag = mem_addr_o[31:OFF_W+IDX_W+2];
   assign unused_pc_bits = ^pc_i[1:0];

   // Lookup is only trusted while no refill is in flight
   assign hit        = (state == IDLE) & tag_hit;
   assign stall_o    = fetch_req_i & ~hit;
   assign instr_o    = hit ? data_q[pc_idx][pc_off] : NOP;
   // An invalidate in the same cycle suppresses the miss
   assign miss_start = (state == IDLE) & fetch_req_i & ~hit & ~inv_i;
   // Beats outside FILL (e.g. stragglers after reset) never touch the arrays
   assign fill_we    = (state == FILL) & mem_rvalid_i;
   assign last_beat  = fill_we & (beat == OFF_W'(LINE_WORDS - 1));

   icache_tagmem #(
      .NUM_LINES (NUM_LINES),
      .IDX_W     (IDX_W),
      .TAG_W     (TAG_W)
   ) u_tagmem (
      .clk        (clk),
      .reset      (reset),
      .lookup_idx (pc_idx),
      .lookup_tag (pc_tag),
      .lookup_hit (tag_hit),
      .inv_all    (inv_i),
      .wr_en      (last_beat),
      .wr_idx     (miss_idx),
      .wr_tag     (miss_tag),
      .wr_valid   (~(inv_pend | inv_i))
   );

   // Refill controller: latch the missing line, hold the request until granted, count beats
   always_ff @(posedge clk) begin
      if (reset) begin
         state      <= IDLE;
         beat       <= '0;
         inv_pend   <= 1'b0;
         mem_req_o  <= 1'b0;
         mem_addr_o <= '0;
      end else begin
         case (state)
            IDLE: begin
               inv_pend <= 1'b0;
               if (miss_start) begin
                  mem_addr_o <= {pc_i[31:OFF_W+2], {(OFF_W+2){1'b0}}};
                  mem_req_o  <= 1'b1;
                  state      <= REQ;
               end
            end
            REQ: begin
               if (inv_i) begin
                  inv_pend <= 1'b1;
               end
               if (mem_gnt_i) begin
                  mem_req_o <= 1'b0;
                  beat      <= '0;
                  state     <= FILL;
               end
            end
            FILL: begin
               if (inv_i) begin
                  inv_pend <= 1'b1;
               end
               if (fill_we) begin
                  beat <= beat + 1'b1;
                  if (last_beat) begin
                     inv_pend <= 1'b0;
                     state    <= IDLE;
                  end
               end
            end
            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

   // Data array is written beat by beat at the latched miss line; it is never reset
   always_ff @(posedge clk) begin
      if (fill_we) begin
         data_q[miss_idx][beat] <= mem_rdata_i;
      end
   end

`ifdef ICACHE_STATS_EN
   logic [31:0] hit_cnt_q;
   logic [31:0] miss_cnt_q;

   // Free-running wrap-around hit/miss statistics
   always_ff @(posedge clk) begin
      if (reset) begin
         hit_cnt_q  <= '0;
         miss_cnt_q <= '0;
      end else begin
         if (fetch_req_i & hit) begin
            hit_cnt_q <= hit_cnt_q + 32'd1;
         end
         if (miss_start) begin
            miss_cnt_q <= miss_cnt_q + 32'd1;
         end
      end
   end

   assign hit_cnt_o  = hit_cnt_q;
   assign miss_cnt_o = miss_cnt_q;
`else
   assign hit_cnt_o  = 32'h0;
   assign miss_cnt_o = 32'h0;
`endif

endmodule

// File: tb/tb_icache_dm.sv
// Scoreboard bench for icache_dm: a fetch driver pushes expectations from a
// line-level cache model, a monitor pops them when the fetch completes, and
// a memory responder serves refills from a word-addressed memory model.
module tb_icache_dm;

   localparam int NL     = 16;
   localparam int LW     = 4;
   localparam int LINE_B = LW * 4;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        fetch_req_i = 1'b0;
   logic [31:0] pc_i = '0;
   logic [31:0] instr_o;
   logic        stall_o;
   logic        inv_i;
   logic        mem_req_o;
   logic [31:0] mem_addr_o;
   logic        mem_gnt_i = 1'b0;
   logic        mem_rvalid_i;
   logic [31:0] mem_rdata_i;
   logic [31:0] hit_cnt_o;
   logic [31:0] miss_cnt_o;

   logic        stim_inv = 1'b0;
   logic        resp_inv = 1'b0;
   logic        resp_rvalid = 1'b0;
   logic        stray_rvalid = 1'b0;
   logic [31:0] resp_rdata = '0;
   logic [31:0] stray_rdata = '0;

   assign inv_i        = stim_inv | resp_inv;
   assign mem_rvalid_i = resp_rvalid | stray_rvalid;
   assign mem_rdata_i  = stray_rvalid ? stray_rdata : resp_rdata;

   icache_dm #(.NUM_LINES(NL), .LINE_WORDS(LW)) dut (
      .clk          (clk),
      .reset        (reset),
      .fetch_req_i  (fetch_req_i),
      .pc_i         (pc_i),
      .instr_o      (instr_o),
      .stall_o      (stall_o),
      .inv_i        (inv_i),
      .mem_req_o    (mem_req_o),
      .mem_addr_o   (mem_addr_o),
      .mem_gnt_i    (mem_gnt_i),
      .mem_rvalid_i (mem_rvalid_i),
      .mem_rdata_i  (mem_rdata_i),
      .hit_cnt_o    (hit_cnt_o),
      .miss_cnt_o   (miss_cnt_o)
   );

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_fail   = 0;

   typedef struct {
      logic [31:0] pc;
      logic [31:0] instr;
      bit          miss;
      int          lat;
   } exp_t;

   exp_t        sb_q[$];
   logic [31:0] addr_q[$];

   // Memory model and line-level cache model
   logic [31:0] mem_m [logic [31:0]];
   bit          valid_m [NL];
   logic [31:0] tag_m [NL];

   // Responder configuration
   int gnt_delay   = 0;
   bit gap_en      = 1'b0;
   int inv_fill_no = -1;
   int fill_no     = 0;
   int abort_beats = -1;
   int abort_cnt   = 0;

   task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
      end
   endtask

   function automatic logic [31:0] mem_rd(input logic [31:0] a);
      if (!mem_m.exists(a)) mem_m[a] = $urandom;
      return mem_m[a];
   endfunction

   function automatic void model_clear();
      for (int i = 0; i < NL; i++) valid_m[i] = 1'b0;
   endfunction

   // Monitor: a fetch completes when the DUT drops stall with fetch_req_i high
   int stall_cyc = 0;
   always @(negedge clk) begin : monitor
      exp_t e;
      if (!reset && fetch_req_i && sb_q.size() > 0) begin
         if (stall_o) begin
            stall_cyc++;
         end else begin
            e = sb_q.pop_front();
            check32($sformatf("instr@%h", e.pc), instr_o, e.instr);
            check32($sformatf("miss@%h", e.pc), 32'(stall_cyc > 0), 32'(e.miss));
            if (e.lat >= 0) check32($sformatf("latency@%h", e.pc), 32'(stall_cyc), 32'(e.lat));
            stall_cyc = 0;
         end
      end
   end

   // Memory responder: grant after gnt_delay, then LW beats (optionally gapped)
   initial begin : responder
      logic [31:0] base;
      forever begin
         @(negedge clk);
         if (!reset && mem_req_o) begin
            base = mem_addr_o;
            fill_no++;
            if (addr_q.size() == 0) begin
               n_checks++;
               n_fail++;
               $display("FAIL unexpected_refill: got request for %h, expected none", base);
            end else begin
               check32("refill_addr", base, addr_q.pop_front());
            end
            for (int d = 0; d < gnt_delay; d++) begin
               @(negedge clk);
               check32("req_held", 32'(mem_req_o), 32'd1);
               check32("addr_held", mem_addr_o, base);
               check32("stall_in_req", 32'(stall_o), 32'(fetch_req_i));
            end
            mem_gnt_i = 1'b1;
            @(negedge clk);
            mem_gnt_i = 1'b0;
            check32("req_dropped", 32'(mem_req_o), 32'd0);
            for (int b = 0; b < LW; b++) begin
               if (b == abort_beats) begin
                  abort_cnt++;
                  break;
               end
               if (gap_en) repeat ($urandom_range(0, 2)) @(negedge clk);
               resp_rvalid = 1'b1;
               resp_rdata  = mem_rd(base + 32'(4 * b));
               resp_inv    = (fill_no == inv_fill_no) && (b == 2);
               @(negedge clk);
               resp_rvalid = 1'b0;
               resp_inv    = 1'b0;
            end
         end
      end
   end

   // Issue one fetch, pushing the model's prediction, and hold it until served
   task automatic do_fetch(input logic [31:0] pc, input bit with_inv);
      exp_t        e;
      int          idx;
      logic [31:0] tag;
      logic [31:0] base;
      bit          done;
      idx     = int'((pc / LINE_B) % NL);
      tag     = pc / (LINE_B * NL);
      base    = pc - (pc % LINE_B);
      e.pc    = pc;
      e.instr = mem_rd(pc & ~32'h3);
      e.miss  = !(valid_m[idx] && tag_m[idx] == tag);
      if (!e.miss) e.lat = 0;
      else if (gnt_delay == 0 && !gap_en && !with_inv) e.lat = LW + 2;
      else e.lat = -1;
      if (e.miss) begin
         addr_q.push_back(base);
         if (with_inv) begin
            inv_fill_no = fill_no + 1;
            addr_q.push_back(base);
            model_clear();
         end
         valid_m[idx] = 1'b1;
         tag_m[idx]   = tag;
      end
      sb_q.push_back(e);
      fetch_req_i = 1'b1;
      pc_i        = pc;
      done        = 1'b0;
      for (int k = 0; k < 400 && !done; k++) begin
         @(negedge clk);
         if (!stall_o) done = 1'b1;
      end
      if (!done) begin
         $display("FAIL fetch_timeout@%h: stall_o still 1, expected release within 400 cycles", pc);
         $fatal(1, "fetch timeout");
      end
      @(posedge clk);
      #1;
      fetch_req_i = 1'b0;
      inv_fill_no = -1;
   endtask

   task automatic inv_pulse();
      stim_inv = 1'b1;
      @(posedge clk);
      #1;
      stim_inv = 1'b0;
      model_clear();
   endtask

   initial begin : watchdog
      #500000;
      $display("FAIL watchdog: simulation still running, expected completion");
      $fatal(1, "watchdog");
   end

   initial begin : stimulus
      int  snap;
      bit  done;
      mem_m[32'h0] = 32'h20020005;
      mem_m[32'h4] = 32'h2003000C;
      mem_m[32'h8] = 32'h2067FFF7;
      mem_m[32'hC] = 32'h00E22025;
      model_clear();

      repeat (3) @(posedge clk);
      #1;
      reset = 1'b0;
      @(negedge clk);
      check32("rst_stall", 32'(stall_o), 32'd0);
      check32("rst_mem_req", 32'(mem_req_o), 32'd0);
      check32("rst_mem_addr", mem_addr_o, 32'h0);
      check32("rst_instr", instr_o, 32'h0);
      check32("rst_hit_cnt", hit_cnt_o, 32'h0);
      check32("rst_miss_cnt", miss_cnt_o, 32'h0);
      @(posedge clk);
      #1;

      // Basic miss, refill and hit
      gnt_delay = 0;
      gap_en    = 1'b0;
      do_fetch(32'h00, 1'b0);
      do_fetch(32'h08, 1'b0);
`ifdef ICACHE_STATS_EN
      check32("stats_miss", miss_cnt_o, 32'd1);
      check32("stats_hit", hit_cnt_o, 32'd2);
`else
      check32("stats_miss_off", miss_cnt_o, 32'd0);
      check32("stats_hit_off", hit_cnt_o, 32'd0);
`endif

      // Conflict on index 0
      do_fetch(32'h100, 1'b0);
      do_fetch(32'h00, 1'b0);

      // Withheld grant and gapped beats
      gnt_delay = 5;
      gap_en    = 1'b1;
      do_fetch(32'h40, 1'b0);
      gnt_delay = 0;
      gap_en    = 1'b0;
      do_fetch(32'h4C, 1'b0);

      // Invalidate during a fill, then in IDLE
      do_fetch(32'h80, 1'b1);
      do_fetch(32'h84, 1'b0);
      inv_pulse();
      do_fetch(32'h88, 1'b0);

      // Reset mid-fill followed by stray beats
      addr_q.push_back(32'h1C0);
      abort_beats = 2;
      snap        = abort_cnt;
      fetch_req_i = 1'b1;
      pc_i        = 32'h1C0;
      done        = 1'b0;
      for (int k = 0; k < 100 && !done; k++) begin
         @(negedge clk);
         if (abort_cnt != snap) done = 1'b1;
      end
      if (!done) begin
         $display("FAIL abort_timeout: fill never reached beat 2, expected within 100 cycles");
         $fatal(1, "abort timeout");
      end
      reset       = 1'b1;
      fetch_req_i = 1'b0;
      @(negedge clk);
      reset = 1'b0;
      abort_beats = -1;
      check32("midfill_rst_req", 32'(mem_req_o), 32'd0);
      check32("midfill_rst_addr", mem_addr_o, 32'h0);
      check32("midfill_rst_stall", 32'(stall_o), 32'd0);
      stray_rvalid = 1'b1;
      stray_rdata  = 32'hDEADBEEF;
      repeat (2) @(negedge clk);
      stray_rvalid = 1'b0;
      check32("stray_no_req", 32'(mem_req_o), 32'd0);
      model_clear();
      @(posedge clk);
      #1;
      do_fetch(32'h1C0, 1'b0);
      do_fetch(32'h1C4, 1'b0);

      // Randomised traffic over four tags sharing the index space
      for (int n = 0; n < 80; n++) begin
         gnt_delay = $urandom_range(0, 3);
         gap_en    = ($urandom_range(0, 1) == 1);
         if ($urandom_range(0, 9) == 0) inv_pulse();
         if ($urandom_range(0, 9) == 0) begin
            repeat ($urandom_range(1, 3)) @(posedge clk);
            #1;
         end
         do_fetch((32'($urandom_range(0, 3)) << 8) | (32'($urandom_range(0, 63)) << 2), 1'b0);
      end

      repeat (10) @(negedge clk);
      check32("sb_drained", 32'(sb_q.size()), 32'd0);
      check32("refills_drained", 32'(addr_q.size()), 32'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
